// File: rtl/nonce_dispatch_ctrl.sv
// nonce_dispatch_ctrl: sweeps a nonce range over NUM_CORES hash cores with round-robin loads.
// Optional macro NONCE_ABORT_EN adds an abort input and a core_flush output.

module nonce_dispatch_lane (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic grant,
  input  logic ready,
  input  logic done,
  input  logic hit,
  output logic pending,
  output logic eligible,
  output logic hit_vld
);
  // A grant only goes to an idle core, so a stray done on that core loses to the grant.
  always_ff @(posedge clk) begin
    if (!reset || clear) pending <= 1'b0;
    else if (grant)      pending <= 1'b1;
    else if (done)       pending <= 1'b0;
  end

  assign eligible = ready & ~pending;
  assign hit_vld  = done & hit & pending;
endmodule

module nonce_dispatch_ctrl #(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NONCE_W-1:0]           nonce_start,
  input  logic [NONCE_W-1:0]           nonce_end,
  input  logic [NUM_CORES-1:0]         core_ready,
  input  logic [NUM_CORES-1:0]         core_done,
  input  logic [NUM_CORES-1:0]         core_hit,
  input  logic [NUM_CORES*NONCE_W-1:0] core_nonce_res,
`ifdef NONCE_ABORT_EN
  input  logic                         abort,
  output logic [NUM_CORES-1:0]         core_flush,
`endif
  output logic [NUM_CORES-1:0]         core_load,
  output logic [NONCE_W-1:0]           core_nonce,
  output logic                         busy,
  output logic                         valid_out,
  output logic [NONCE_W-1:0]           nonce_out,
  output logic                         finished
);
  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

  state_t                             state;
  logic                               start_q, hit_cap, abort_i;
  logic [NONCE_W-1:0]                 next_nonce, end_reg;
  logic [PW-1:0]                      ptr, gidx, hidx;
  logic                               any_grant, any_hit;
  int                                 idx;
  logic [NUM_CORES-1:0]               pending, eligible, hit_vec, grant;
  logic [NUM_CORES-1:0][NONCE_W-1:0]  res;

  assign res = core_nonce_res;

`ifdef NONCE_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
    nonce_dispatch_lane u_lane (
      .clk      (clk),
      .reset    (reset),
      .clear    (state == DONE),
      .grant    (grant[i]),
      .ready    (core_ready[i]),
      .done     (core_done[i]),
      .hit      (core_hit[i]),
      .pending  (pending[i]),
      .eligible (eligible[i]),
      .hit_vld  (hit_vec[i])
    );
  end

  // Round-robin search from ptr; lowest index wins among simultaneous hits.
  always_comb begin
    any_grant = 1'b0;
    gidx      = '0;
    idx       = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = (int'(ptr) + k) % NUM_CORES;
      if (!any_grant && eligible[idx]) begin
        any_grant = 1'b1;
        gidx      = PW'(idx);
      end
    end
    any_hit = 1'b0;
    hidx    = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        any_hit = 1'b1;
        hidx    = PW'(i);
      end
    end
    grant = '0;
    if (state == DISPATCH && !abort_i && !any_hit && any_grant) grant[gidx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      hit_cap    <= 1'b0;
      next_nonce <= '0;
      end_reg    <= '0;
      ptr        <= '0;
      core_load  <= '0;
      core_nonce <= '0;
      busy       <= 1'b0;
      valid_out  <= 1'b0;
      nonce_out  <= '0;
      finished   <= 1'b0;
`ifdef NONCE_ABORT_EN
      core_flush <= '0;
`endif
    end else begin
      start_q   <= start;
      core_load <= '0;
      valid_out <= 1'b0;
      finished  <= 1'b0;
`ifdef NONCE_ABORT_EN
      core_flush <= '0;
`endif
      case (state)
        IDLE: begin
          if (start && !start_q) begin
            next_nonce <= nonce_start;
            end_reg    <= nonce_end;
            nonce_out  <= '0;
            hit_cap    <= 1'b0;
            if (nonce_start > nonce_end) begin
              state <= DONE;
            end else begin
              state <= DISPATCH;
              busy  <= 1'b1;
            end
          end
        end
        DISPATCH, DRAIN: begin
          if (abort_i) begin
            state   <= DONE;
            busy    <= 1'b0;
            hit_cap <= 1'b0;
`ifdef NONCE_ABORT_EN
            core_flush <= pending;
`endif
          end else if (any_hit) begin
            nonce_out <= res[hidx];
            hit_cap   <= 1'b1;
            state     <= DONE;
            busy      <= 1'b0;
          end else if (state == DRAIN) begin
            if (pending == '0) begin
              state <= DONE;
              busy  <= 1'b0;
            end
          end else if (any_grant) begin
            core_load  <= grant;
            core_nonce <= next_nonce;
            next_nonce <= next_nonce + 1'b1;
            ptr        <= (int'(gidx) == NUM_CORES - 1) ? '0 : gidx + 1'b1;
            // Compare against the issued nonce, not overflow, so an all-ones end works.
            if (next_nonce == end_reg) state <= DRAIN;
          end
        end
        DONE: begin
          finished  <= 1'b1;
          valid_out <= hit_cap;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nonce_dispatch_ctrl.sv
// Testbench for nonce_dispatch_ctrl: table-driven jobs, hand sequences, randomized jobs
// checked every cycle against a behavioural model and an emulated set of hash cores.
module tb_nonce_dispatch_ctrl;
  localparam int NC = 4;
  localparam int NW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [NW-1:0] nonce_start = '0, nonce_end = '0;
  logic [NC-1:0] core_ready = '0, core_done = '0, core_hit = '0;
  logic [NC-1:0][NW-1:0] res_arr = '0;
  logic [NC-1:0] core_load;
  logic [NW-1:0] core_nonce, nonce_out;
  logic busy, valid_out, finished;
`ifdef NONCE_ABORT_EN
  logic abort = 1'b0;
  logic [NC-1:0] core_flush;
`endif

  nonce_dispatch_ctrl #(.NUM_CORES(NC), .NONCE_W(NW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .nonce_start(nonce_start), .nonce_end(nonce_end),
    .core_ready(core_ready), .core_done(core_done), .core_hit(core_hit),
    .core_nonce_res(res_arr),
`ifdef NONCE_ABORT_EN
    .abort(abort), .core_flush(core_flush),
`endif
    .core_load(core_load), .core_nonce(core_nonce), .busy(busy),
    .valid_out(valid_out), .nonce_out(nonce_out), .finished(finished)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // reference model: job phase 0 idle, 1 sweeping, 2 waiting for stragglers, 3 reporting
  int            m_st = 0, m_ptr = 0;
  logic [NW-1:0] m_next = '0, m_end = '0, m_nout = '0, m_cn = '0;
  logic [NC-1:0] m_out = '0;
  logic          m_hit = 1'b0, m_sq = 1'b0;

  // emulated hash cores
  logic          h_auto = 1'b0;
  int            h_busy[NC], h_cnt[NC], h_ndone[NC], lat[NC], hit_nth[NC];
  logic [NW-1:0] h_nonce[NC], hit_res[NC];
  int            rdy_pct = 100, hit_pm = 0;

  // per-job observations
  int            n_loads = 0, n_fin = 0;
  logic          f_val = 1'b0;
  logic [NW-1:0] f_nout = '0, first_nonce = '0;
  int            load_core_q[$];

  typedef struct {
    logic [NW-1:0] ns, ne;
    int            hcore, hnth;
    logic [NW-1:0] hres;
    int            exp_loads;
    logic          exp_val;
    logic [NW-1:0] exp_nout;
    int            exp_fcyc;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    logic [NC-1:0] r, d, h;
    r = '0; d = '0; h = '0;
    for (int i = 0; i < NC; i++) begin
      res_arr[i] = h_nonce[i];
      if (h_busy[i] != 0) begin
        if (h_cnt[i] == 1) begin
          d[i] = 1'b1; h_busy[i] = 0; h_ndone[i]++;
          if (hit_nth[i] == h_ndone[i]) begin h[i] = 1'b1; res_arr[i] = hit_res[i]; end
          else if ($urandom_range(999) < hit_pm) h[i] = 1'b1;
        end else h_cnt[i]--;
      end else if (hit_pm > 0 && $urandom_range(9) == 0) h[i] = 1'b1;  // hit without done
      if (h_busy[i] == 0 && !d[i] && $urandom_range(99) < rdy_pct) r[i] = 1'b1;
    end
    core_ready = r; core_done = d; core_hit = h;
  endtask

  task automatic cyc();
    logic [NC-1:0] e_load, elig, hits, e_flush;
    logic e_fin, e_val, abort_now;
    int g;
    @(posedge clk); #1;
    e_load = '0; e_fin = 1'b0; e_val = 1'b0; e_flush = '0; g = -1;
`ifdef NONCE_ABORT_EN
    abort_now = abort;
`else
    abort_now = 1'b0;
`endif
    if (!reset) begin
      m_st = 0; m_out = '0; m_ptr = 0; m_hit = 1'b0; m_nout = '0; m_sq = 1'b0; m_cn = '0;
    end else begin
      elig = core_ready & ~m_out;
      hits = core_done & core_hit & m_out;
      case (m_st)
        0: if (start && !m_sq) begin
             m_nout = '0; m_hit = 1'b0; m_next = nonce_start; m_end = nonce_end;
             m_st = (nonce_start > nonce_end) ? 3 : 1;
           end
        1, 2: begin
          if (abort_now) begin
            e_flush = m_out; m_hit = 1'b0; m_st = 3;
          end else if (hits != 0) begin
            for (int i = NC - 1; i >= 0; i--) if (hits[i]) g = i;
            m_nout = res_arr[g]; m_hit = 1'b1; m_st = 3;
          end else if (m_st == 2) begin
            if (m_out == 0) m_st = 3;
          end else begin
            for (int k = 0; k < NC; k++) if (g < 0 && elig[(m_ptr + k) % NC]) g = (m_ptr + k) % NC;
            if (g >= 0) begin
              e_load[g] = 1'b1; m_cn = m_next; m_ptr = (g + 1) % NC;
              if (m_next == m_end) m_st = 2;
              m_next = m_next + 1;
            end
          end
          m_out = m_out & ~core_done;
          if (e_load != 0) m_out[g] = 1'b1;
        end
        default: begin e_fin = 1'b1; e_val = m_hit; m_out = '0; m_st = 0; end
      endcase
      m_sq = start;
    end
    chk("core_load", core_load, e_load);
    if (e_load != 0) chk("core_nonce", core_nonce, m_cn);
    chk("busy", busy, (m_st == 1 || m_st == 2));
    chk("finished", finished, e_fin);
    chk("valid_out", valid_out, e_val);
    chk("nonce_out", nonce_out, m_nout);
`ifdef NONCE_ABORT_EN
    chk("core_flush", core_flush, e_flush);
`endif
    for (int i = 0; i < NC; i++) if (core_load[i]) begin
      h_busy[i] = 1; h_cnt[i] = (lat[i] > 0) ? lat[i] : int'($urandom_range(5, 1));
      h_nonce[i] = core_nonce; n_loads++; load_core_q.push_back(i);
      if (n_loads == 1) first_nonce = core_nonce;
    end
    if (finished) begin n_fin++; f_val = valid_out; f_nout = nonce_out; end
    if (h_auto) drive();
  endtask

  task automatic h_clear();
    for (int i = 0; i < NC; i++) begin
      h_busy[i] = 0; h_cnt[i] = 0; h_ndone[i] = 0; h_nonce[i] = '0; hit_nth[i] = 0; hit_res[i] = '0;
    end
    core_ready = '0; core_done = '0; core_hit = '0; res_arr = '0;
  endtask

  task automatic clr_stats();
    n_loads = 0; n_fin = 0; f_val = 1'b0; f_nout = '0; first_nonce = '0; load_core_q.delete();
    for (int i = 0; i < NC; i++) h_ndone[i] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; h_clear();
    cyc(); cyc();
    reset = 1'b1; h_clear();
    if (h_auto) drive();
  endtask

  task automatic run_job(input logic [NW-1:0] ns, input logic [NW-1:0] ne, input logic tog, output int fcyc);
    clr_stats();
    fcyc = -1;
    nonce_start = ns; nonce_end = ne; start = 1'b1;
    for (int c = 1; c <= 3000 && n_fin == 0; c++) begin
      cyc();
      if (n_fin != 0) fcyc = c;
      else if (tog && c >= 2) start = 1'($urandom_range(1));
    end
    chk("job_finished", n_fin, 1);
    start = 1'b0;
    for (int c = 0; c < 50; c++) cyc();
    chk("finish_once", n_fin, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int fc;
    logic [NW-1:0] ns, ne;
    int len;
    tbl[0] = '{32'h10, 32'h17, -1, 0, 32'h0, 8, 1'b0, 32'h0, 14};
    tbl[1] = '{32'h0, 32'hFF, 2, 1, 32'h6, 5, 1'b1, 32'h6, 8};
    tbl[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, -1, 0, 32'h0, 2, 1'b0, 32'h0, 8};
    tbl[3] = '{32'h5, 32'h4, -1, 0, 32'h0, 0, 1'b0, 32'h0, 2};
    tbl[4] = '{32'h7, 32'h7, -1, 0, 32'h0, 1, 1'b0, 32'h0, 7};
    tbl[5] = '{32'h40, 32'h41, 1, 1, 32'h41, 2, 1'b1, 32'h41, 7};

    h_clear();
    h_auto = 1'b1;
    do_reset();
    chk("rst_core_load", core_load, 0);
    chk("rst_core_nonce", core_nonce, 0);
    chk("rst_busy", busy, 0);
    chk("rst_nonce_out", nonce_out, 0);
    chk("rst_flags", {valid_out, finished}, 0);

    for (int t = 0; t < 6; t++) begin
      rdy_pct = 100; hit_pm = 0;
      for (int i = 0; i < NC; i++) lat[i] = 3;
      do_reset();
      if (tbl[t].hcore >= 0) begin
        hit_nth[tbl[t].hcore] = tbl[t].hnth;
        hit_res[tbl[t].hcore] = tbl[t].hres;
      end
      run_job(tbl[t].ns, tbl[t].ne, 1'b0, fc);
      chk($sformatf("t%0d_loads", t), n_loads, tbl[t].exp_loads);
      chk($sformatf("t%0d_valid", t), f_val, tbl[t].exp_val);
      chk($sformatf("t%0d_nonce_out", t), f_nout, tbl[t].exp_nout);
      chk($sformatf("t%0d_fin_cycle", t), fc, tbl[t].exp_fcyc);
      if (tbl[t].exp_loads > 0) chk($sformatf("t%0d_first_nonce", t), first_nonce, tbl[t].ns);
      if (t == 0)
        for (int k = 0; k < load_core_q.size(); k++) chk($sformatf("rr_core_%0d", k), load_core_q[k], k % NC);
    end

    // simultaneous hits on cores 1 and 3
    h_auto = 1'b0;
    do_reset();
    clr_stats();
    core_ready = '1; nonce_start = 32'h20; nonce_end = 32'hFF; start = 1'b1;
    repeat (5) cyc();
    core_ready = '0;
    cyc();
    core_done = 4'b1010; core_hit = 4'b1010;
    res_arr[1] = 32'h21; res_arr[3] = 32'h23;
    cyc();
    core_done = '0; core_hit = '0;
    cyc();
    chk("simul_loads", n_loads, 4);
    chk("simul_fin", n_fin, 1);
    chk("simul_valid", f_val, 1);
    chk("simul_nonce_out", f_nout, 32'h21);
    start = 1'b0;
    repeat (3) cyc();

    // reset in the middle of a sweep, then a fresh job
    h_auto = 1'b1;
    for (int i = 0; i < NC; i++) lat[i] = 3;
    do_reset();
    clr_stats();
    nonce_start = 32'h100; nonce_end = 32'h1FF; start = 1'b1;
    for (int c = 0; c < 50 && n_loads < 3; c++) cyc();
    chk("mid_loads", n_loads, 3);
    reset = 1'b0;
    cyc();
    chk("mid_rst_load", core_load, 0);
    chk("mid_rst_nonce", core_nonce, 0);
    chk("mid_rst_flags", {busy, valid_out, finished}, 0);
    chk("mid_rst_nonce_out", nonce_out, 0);
    reset = 1'b1; start = 1'b0; h_clear();
    cyc(); cyc();
    run_job(32'h100, 32'h103, 1'b0, fc);
    chk("fresh_loads", n_loads, 4);
    chk("fresh_first_nonce", first_nonce, 32'h100);
    chk("fresh_first_core", load_core_q[0], 0);

`ifdef NONCE_ABORT_EN
    for (int i = 0; i < NC; i++) lat[i] = 5;
    do_reset();
    clr_stats();
    nonce_start = 32'h0; nonce_end = 32'h1; start = 1'b1;
    repeat (3) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_flush", core_flush, 4'b0011);
    cyc();
    chk("abort_fin", finished, 1);
    chk("abort_valid", valid_out, 0);
    start = 1'b0;
    repeat (10) cyc();
`endif

    // randomized jobs
    for (int j = 0; j < 40; j++) begin
      rdy_pct = $urandom_range(100, 30);
      hit_pm  = (j % 3 == 0) ? 0 : int'($urandom_range(150, 10));
      for (int i = 0; i < NC; i++) begin lat[i] = $urandom_range(4, 0); hit_nth[i] = 0; end
      len = $urandom_range(20, 0);
      ns = $urandom;
      case ($urandom_range(3))
        0: begin ns = 32'hFFFF_FFFF - len; ne = 32'hFFFF_FFFF; end
        1: ne = ns - 1;
        default: ne = ns + len;
      endcase
      run_job(ns, ne, 1'b1, fc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
